// File: rtl/taus88_multi.sv
// rtl/taus88_multi.sv - multi-lane Taus88 generator with LCG seed expansion and warm-up
//
// Purpose: NUM_LANES independent 32-bit Taus88 streams delivered as one wide
// beat over a valid/ready handshake. A 32-bit seed is expanded by an LCG into
// all 3*NUM_LANES component words, then WARMUP steps are discarded.
//
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   seed       - seed word, taken when seed_valid && seed_ready
//   seed_valid - seed offered
//   seed_ready - high in WARMUP and RUN
//   rnd        - lane i on bits [32i+31:32i]
//   rnd_valid  - rnd holds a valid beat (RUN)
//   rnd_ready  - consumer accepts beat
//   seeding    - high while in SEED or WARMUP
module taus88_multi #(
  parameter int          NUM_LANES    = 4,
  parameter int          WARMUP       = 8,
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             seed,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  output logic [32*NUM_LANES-1:0] rnd,
  output logic                    rnd_valid,
  input  logic                    rnd_ready,
  output logic                    seeding
);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] s1_q [NUM_LANES];
  logic [31:0] s2_q [NUM_LANES];
  logic [31:0] s3_q [NUM_LANES];
  logic [31:0] s1_d [NUM_LANES];
  logic [31:0] s2_d [NUM_LANES];
  logic [31:0] s3_d [NUM_LANES];
  logic [31:0] word_q;
  logic [31:0] word_d;
  logic [31:0] fix_d;
  logic [3:0]  lane_q;
  logic [1:0]  comp_q;
  logic [7:0]  warm_q;
  logic        rnd_valid_q;
  logic        seed_ready_q;
  logic        seeding_q;

  logic seed_fire;
  logic rnd_fire;
  logic last_word;
  logic warm_done;

  function automatic logic [31:0] step1(input logic [31:0] s);
    return ((s & ~32'h1) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    return ((s & ~32'h7) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step3(input logic [31:0] s);
    return ((s & ~32'hF) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  assign seed_fire = seed_valid && seed_ready_q;
  assign rnd_fire  = rnd_valid_q && rnd_ready;
  assign last_word = (lane_q == 4'(NUM_LANES - 1)) && (comp_q == 2'd2);
  assign warm_done = (warm_q == 8'(WARMUP - 1));

  // LCG keeps only the low 32 bits of the product.
  assign word_d = word_q * 32'd69069 + 32'd1;

  // Force the minimum magnitude each Taus88 component needs; the LCG chain
  // itself continues from the raw word.
  always_comb begin
    fix_d = word_q;
    case (comp_q)
      2'd0:    if (word_q[31:1] == '0) fix_d[1] = 1'b1;
      2'd1:    if (word_q[31:3] == '0) fix_d[3] = 1'b1;
      default: if (word_q[31:4] == '0) fix_d[4] = 1'b1;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      s1_d[i] = step1(s1_q[i]);
      s2_d[i] = step2(s2_q[i]);
      s3_d[i] = step3(s3_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEED;
      word_q       <= DEFAULT_SEED;
      lane_q       <= '0;
      comp_q       <= '0;
      warm_q       <= '0;
      rnd_valid_q  <= 1'b0;
      seed_ready_q <= 1'b0;
      seeding_q    <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
        s3_q[i] <= '0;
      end
    end else if (seed_fire) begin
      // A new seed wins over a same-cycle rnd beat: the beat is delivered,
      // but the lanes are not stepped since seeding overwrites them.
      state_q      <= ST_SEED;
      word_q       <= seed;
      lane_q       <= '0;
      comp_q       <= '0;
      warm_q       <= '0;
      rnd_valid_q  <= 1'b0;
      seed_ready_q <= 1'b0;
      seeding_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_SEED: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == 4'(i)) begin
              case (comp_q)
                2'd0:    s1_q[i] <= fix_d;
                2'd1:    s2_q[i] <= fix_d;
                default: s3_q[i] <= fix_d;
              endcase
            end
          end
          word_q <= word_d;
          if (last_word) begin
            lane_q       <= '0;
            comp_q       <= '0;
            seed_ready_q <= 1'b1;
            if (WARMUP == 0) begin
              state_q     <= ST_RUN;
              rnd_valid_q <= 1'b1;
              seeding_q   <= 1'b0;
            end else begin
              state_q <= ST_WARMUP;
            end
          end else if (comp_q == 2'd2) begin
            comp_q <= '0;
            lane_q <= lane_q + 4'd1;
          end else begin
            comp_q <= comp_q + 2'd1;
          end
        end

        ST_WARMUP: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            s1_q[i] <= s1_d[i];
            s2_q[i] <= s2_d[i];
            s3_q[i] <= s3_d[i];
          end
          if (warm_done) begin
            warm_q      <= '0;
            state_q     <= ST_RUN;
            rnd_valid_q <= 1'b1;
            seeding_q   <= 1'b0;
          end else begin
            warm_q <= warm_q + 8'd1;
          end
        end

        ST_RUN: begin
          if (rnd_fire) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              s1_q[i] <= s1_d[i];
              s2_q[i] <= s2_d[i];
              s3_q[i] <= s3_d[i];
            end
          end
        end

        default: begin
          state_q      <= ST_SEED;
          lane_q       <= '0;
          comp_q       <= '0;
          rnd_valid_q  <= 1'b0;
          seed_ready_q <= 1'b0;
          seeding_q    <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign rnd[32*g +: 32] = s1_q[g] ^ s2_q[g] ^ s3_q[g];
  end

  assign rnd_valid  = rnd_valid_q;
  assign seed_ready = seed_ready_q;
  assign seeding    = seeding_q;

endmodule

// File: tb/tb_taus88_multi.sv
// tb/tb_taus88_multi.sv - self-checking bench for taus88_multi (two configurations)
module tb_taus88_multi;

  localparam int N0 = 4;
  localparam int W0 = 8;
  localparam int N1 = 1;
  localparam int W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [31:0]  seed0, seed1;
  logic         seed_valid0, seed_valid1;
  logic         seed_ready0, seed_ready1;
  logic [127:0] rnd0;
  logic [31:0]  rnd1;
  logic         rnd_valid0, rnd_valid1;
  logic         rnd_ready0, rnd_ready1;
  logic         seeding0, seeding1;

  taus88_multi #(.NUM_LANES(N0), .WARMUP(W0), .DEFAULT_SEED(32'h0000_0001)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed(seed0), .seed_valid(seed_valid0),
    .seed_ready(seed_ready0), .rnd(rnd0), .rnd_valid(rnd_valid0),
    .rnd_ready(rnd_ready0), .seeding(seeding0)
  );

  taus88_multi #(.NUM_LANES(N1), .WARMUP(W1), .DEFAULT_SEED(32'h0000_0001)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed(seed1), .seed_valid(seed_valid1),
    .seed_ready(seed_ready1), .rnd(rnd1), .rnd_valid(rnd_valid1),
    .rnd_ready(rnd_ready1), .seeding(seeding1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: per lane i, S1/S2/S3 at bits [96i +: 32], [96i+32 +: 32], [96i+64 +: 32].
  logic [1535:0] m_st [2];
  int            m_cnt [2];
  logic [1535:0] pin_st;
  int            first_valid;

  function automatic int nl(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic int wu(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic logic [1535:0] step_all(input logic [1535:0] st, input int n);
    logic [31:0] a, b, c;
    for (int i = 0; i < n; i++) begin
      a = st[96*i +: 32];
      b = st[96*i+32 +: 32];
      c = st[96*i+64 +: 32];
      st[96*i +: 32]    = ((a & ~32'h1) << 12) ^ (((a << 13) ^ a) >> 19);
      st[96*i+32 +: 32] = ((b & ~32'h7) << 4)  ^ (((b << 2) ^ b) >> 25);
      st[96*i+64 +: 32] = ((c & ~32'hF) << 17) ^ (((c << 3) ^ c) >> 11);
    end
    return st;
  endfunction

  // Full seed expansion plus warm-up, done in one go.
  function automatic logic [1535:0] expand(input logic [31:0] sd, input int n, input int w);
    logic [1535:0] st;
    logic [31:0]   word, v;
    st   = '0;
    word = sd;
    for (int k = 0; k < 3*n; k++) begin
      v = word;
      if ((k % 3) == 0 && v < 32'd2)  v = v | 32'h2;
      if ((k % 3) == 1 && v < 32'd8)  v = v | 32'h8;
      if ((k % 3) == 2 && v < 32'd16) v = v | 32'h10;
      st[32*k +: 32] = v;
      word = word * 32'd69069 + 32'd1;
    end
    for (int j = 0; j < w; j++) st = step_all(st, n);
    return st;
  endfunction

  function automatic logic [31:0] lane_out(input logic [1535:0] st, input int i);
    return st[96*i +: 32] ^ st[96*i+32 +: 32] ^ st[96*i+64 +: 32];
  endfunction

  function automatic logic exp_ready(input int d);
    return rst_n && (m_cnt[d] >= 3*nl(d));
  endfunction

  function automatic logic exp_valid(input int d);
    return rst_n && (m_cnt[d] >= 3*nl(d) + wu(d));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d]  <= expand(32'h1, nl(d), wu(d));
        m_cnt[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic logic        sv = (d == 0) ? seed_valid0 : seed_valid1;
        automatic logic        rr = (d == 0) ? rnd_ready0 : rnd_ready1;
        automatic logic [31:0] sd = (d == 0) ? seed0 : seed1;
        if (sv && exp_ready(d)) begin
          m_st[d]  <= expand(sd, nl(d), wu(d));
          m_cnt[d] <= 0;
        end else begin
          if (m_cnt[d] < 3*nl(d) + wu(d)) m_cnt[d] <= m_cnt[d] + 1;
          if (exp_valid(d) && rr) m_st[d] <= step_all(m_st[d], nl(d));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("dut0 seed_ready", 32'(seed_ready0), 32'(exp_ready(0)));
    chk("dut0 rnd_valid",  32'(rnd_valid0),  32'(exp_valid(0)));
    chk("dut0 seeding",    32'(seeding0),    32'(!exp_valid(0)));
    chk("dut1 seed_ready", 32'(seed_ready1), 32'(exp_ready(1)));
    chk("dut1 rnd_valid",  32'(rnd_valid1),  32'(exp_valid(1)));
    chk("dut1 seeding",    32'(seeding1),    32'(!exp_valid(1)));
    if (exp_valid(0))
      for (int i = 0; i < N0; i++)
        chk($sformatf("dut0 rnd lane%0d", i), rnd0[32*i +: 32], lane_out(m_st[0], i));
    if (exp_valid(1))
      chk("dut1 rnd lane0", rnd1, lane_out(m_st[1], 0));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    seed0 = '0; seed1 = '0;
    seed_valid0 = 1'b0; seed_valid1 = 1'b0;
    rnd_ready0 = 1'b0; rnd_ready1 = 1'b0;

    // Hand-computed anchors for the model itself.
    pin_st = expand(32'h0, 1, 0);
    chk("model seed0 S1", pin_st[31:0],  32'h0000_0002);
    chk("model seed0 S2", pin_st[63:32], 32'h0000_0009);
    chk("model seed0 S3", pin_st[95:64], 32'h0001_0DCE);
    pin_st = step_all(pin_st, 1);
    chk("model step S1", pin_st[31:0],  32'h0000_2000);
    chk("model step S2", pin_st[63:32], 32'h0000_0080);
    chk("model step S3", pin_st[95:64], 32'h1B80_012C);

    repeat (2) tick();
    chk("reset rnd_valid",  32'(rnd_valid0),  32'd0);
    chk("reset seed_ready", 32'(seed_ready0), 32'd0);
    chk("reset seeding",    32'(seeding0),    32'd1);
    chk("reset rnd lane0",  rnd0[31:0],       32'd0);

    // Default-seed expansion after release: 12 seed words + 8 warm-up steps.
    rst_n = 1'b1;
    first_valid = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rnd_valid0 && first_valid < 0) first_valid = c;
      if (c < 20) chk("startup seeding", 32'(seeding0), 32'd1);
    end
    chk("startup first valid cycle", 32'(first_valid), 32'd20);

    // Back-pressure: beat must hold until accepted.
    rnd_ready0 = 1'b0;
    repeat (10) begin
      tick();
      chk("hold rnd_valid", 32'(rnd_valid0), 32'd1);
    end
    rnd_ready0 = 1'b1;
    tick();
    rnd_ready0 = 1'b0;

    // Single-lane, no warm-up: seed 0.
    seed1 = 32'h0; seed_valid1 = 1'b1; rnd_ready1 = 1'b0;
    tick();
    seed_valid1 = 1'b0;
    chk("lane1 valid +0", 32'(rnd_valid1), 32'd0);
    tick();
    chk("lane1 valid +1", 32'(rnd_valid1), 32'd0);
    tick();
    chk("lane1 valid +2", 32'(rnd_valid1), 32'd0);
    tick();
    chk("lane1 valid +3", 32'(rnd_valid1), 32'd1);
    chk("lane1 seed0 rnd", rnd1, 32'h0001_0DC5);
    rnd_ready1 = 1'b1;
    tick();
    rnd_ready1 = 1'b0;
    chk("lane1 seed0 second rnd", rnd1, 32'h1B80_21AC);

    // Reseed in RUN while a beat is being accepted.
    seed0 = 32'h0; seed_valid0 = 1'b1; rnd_ready0 = 1'b1;
    tick();
    seed_valid0 = 1'b0; rnd_ready0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("reseed seed_ready low", 32'(seed_ready0), 32'd0);
      chk("reseed rnd_valid low",  32'(rnd_valid0),  32'd0);
      tick();
    end
    chk("reseed seed_ready back", 32'(seed_ready0), 32'd1);
    repeat (8) tick();
    chk("reseed rnd_valid back", 32'(rnd_valid0), 32'd1);
    rnd_ready0 = 1'b1;
    repeat (5) tick();
    rnd_ready0 = 1'b0;

    // Reset in the middle of warm-up.
    seed0 = $urandom; seed_valid0 = 1'b1;
    tick();
    seed_valid0 = 1'b0;
    repeat (14) tick();
    chk("warmup seed_ready", 32'(seed_ready0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset seed_ready", 32'(seed_ready0), 32'd0);
    chk("async reset rnd_valid",  32'(rnd_valid0),  32'd0);
    chk("async reset seeding",    32'(seeding0),    32'd1);
    chk("async reset rnd lane0",  rnd0[31:0],       32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    rnd_ready0 = 1'b1; rnd_ready1 = 1'b1;
    repeat (25) tick();

    // Randomised traffic on both instances.
    for (int c = 0; c < 2000; c++) begin
      rnd_ready0  = ($urandom_range(0, 3) != 0);
      rnd_ready1  = ($urandom_range(0, 3) != 0);
      seed_valid0 = ($urandom_range(0, 59) == 0);
      seed_valid1 = ($urandom_range(0, 39) == 0);
      seed0       = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      seed1       = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      tick();
    end
    seed_valid0 = 1'b0; seed_valid1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/taus88_multi.md
Name: taus88_multi

Overview:
- Parametrised, multi-lane successor to the single-lane Taus88 generator; produces NUM_LANES independent 32-bit Taus88 streams per beat.
- Valid/ready output handshake; output state only advances when a beat is consumed.
- Seeding FSM expands one 32-bit seed into all 3*NUM_LANES component states via an LCG, enforces Taus88 minimums, then runs a configurable warm-up.
- Sits between the seed/config interface and downstream stochastic consumers.

Parameters:
- NUM_LANES, 4, number of independent Taus88 generators; legal 1..16.
- WARMUP, 8, steps discarded after seeding; legal 0..255.
- DEFAULT_SEED, 32'h0000_0001, seed expanded automatically on reset release.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- seed  in  32  seed word
- seed_valid  in  1  seed offered
- seed_ready  out  1  seed accepted when seed_valid && seed_ready
- rnd  out  32*NUM_LANES  lane i on bits [32i+31:32i]
- rnd_valid  out  1  rnd holds a valid beat
- rnd_ready  in  1  consumer accepts beat
- seeding  out  1  high while in SEED or WARMUP

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low on rst_n.
- Reset values:
  - all component registers 0; rnd_valid=0; seed_ready=0; seeding=1.
  - FSM enters SEED with seed register = DEFAULT_SEED and word index = 0.
- FSM states: SEED -> WARMUP -> RUN. WARMUP is skipped when WARMUP=0.
- SEED (3*NUM_LANES cycles), one word written per cycle:
  - Order: lane0 S1, S2, S3, lane1 S1, ...
  - Word 0 = seed; word k+1 = (69069*word_k + 1) mod 2^32.
  - Fixups: S1 with [31:1]==0 gets bit1 set; S2 with [31:3]==0 gets bit3 set; S3 with [31:4]==0 gets bit4 set.
- WARMUP:
  - all lanes step once per cycle for exactly WARMUP cycles; rnd_valid=0.
- RUN:
  - rnd_valid=1; rnd lane i = S1_i ^ S2_i ^ S3_i (combinational from state registers).
  - All lanes step on the same cycle, only when rnd_valid && rnd_ready; otherwise state and rnd are held.
- Step equations (32-bit, shifts truncate):
  - S1' = ((S1&~1)<<12) ^ (((S1<<13)^S1)>>19)
  - S2' = ((S2&~7)<<4) ^ (((S2<<2)^S2)>>25)
  - S3' = ((S3&~15)<<17) ^ (((S3<<3)^S3)>>11)
- seed_ready = 1 in WARMUP and RUN; 0 in SEED.
  - Seed accepted in WARMUP or RUN: next cycle FSM is in SEED at word 0 with the new seed; rnd_valid=0; warm-up counter cleared.
  - Seeds offered during SEED are not accepted; the sender holds them until seed_ready rises.
- Latency: first rnd_valid occurs 3*NUM_LANES + WARMUP cycles after the seed handshake cycle (or after reset deassertion).
- Seed handshake and rnd handshake in the same cycle:
  - the rnd beat counts as delivered;
  - lane state is not stepped, because it is overwritten by seeding.
- seeding = (state != RUN).
- Reset asserted mid-operation (any state): immediate return to reset values; DEFAULT_SEED expansion restarts on release.
- LCG multiply uses the low 32 bits only; word index and warm-up counter wrap only at their terminal values.

Test Plan:
- NUM_LANES=1, WARMUP=0; accept seed=0 -> states S1=2, S2=9, S3=0x00010DCE; rnd_valid rises 3 cycles after handshake; rnd=0x00010DC5.
- Same config; one rnd handshake -> rnd=0x1B8021AC (S1=0x2000, S2=0x80, S3=0x1B80012C).
- NUM_LANES=4, WARMUP=8; release reset -> rnd_valid stays 0 for 20 cycles; seeding=1 throughout; rnd then matches the golden model expanded from seed 1.
- rnd_ready held 0 for 10 cycles in RUN -> rnd stable and rnd_valid=1 throughout; first accepted beat equals the held value.
- Reseed in RUN with seed=0 while rnd_ready=1 -> that beat counts; rnd_valid=0 next cycle; seed_ready=0 for 12 cycles; stream restarts matching the seed-0 model.
- Reset asserted during WARMUP -> rnd_valid=0 and seeding=1 asynchronously; after release, output is identical to a clean reset.
